fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter controller that sequences the 4096x19 instruction memory.
//  Drives the memory address and receives the combinational read word in the same cycle.
//  Decodes the control-flow opcodes JMP, JSB, RET and the conditional branch.
//  Holds return addresses on an internal stack and passes every fetched word to the datapath.
// PARAMETERS
//  ADDR_W       12   instruction address width; PC wraps modulo 2**ADDR_W
//  INSTR_W      19   instruction word width
//  STACK_DEPTH  8    return-address stack entries; power of two, >=2
//  RESET_PC     0    PC value loaded on reset
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  start        in   1        IDLE->RUN request, sampled on a clk edge
//  stall        in   1        datapath hold; freezes PC and stack
//  flag_z       in   1        ALU zero flag, valid in the fetch cycle
//  flag_c       in   1        ALU carry flag, valid in the fetch cycle
//  instruction  in   INSTR_W  word read from memory at address (same cycle)
//  address      out  ADDR_W   memory address, equal to PC
//  instr_out    out  INSTR_W  fetched word forwarded to datapath
//  instr_valid  out  1        instr_out is to be executed this cycle
//  state        out  2        00 IDLE, 01 RUN, 10 FAULT
//  sp           out  log2(STACK_DEPTH)+1  current stack occupancy
//  fault        out  1        stack guard tripped (guard builds only)
// BEHAVIOUR
//  Reset (rst=0, any time, async): PC=RESET_PC, sp=0, state=IDLE, instr_valid=0, fault=0.
//   Stack contents are don't-care.
//  address=PC combinationally. instr_out=instruction. instr_valid = (state==RUN) & ~stall.
//  IDLE: PC holds. start=1 at an edge -> RUN; the first word is fetched in the next cycle.
//  RUN, stall=1: PC, sp and state hold; instruction is ignored.
//  RUN, stall=0: decode instruction[18:0] and update at the next edge:
//   [18:14]=11100 (JMP)    PC <= instruction[11:0]
//   [18:14]=11101 (JSB)    push PC+1; PC <= instruction[11:0]
//   [18:13]=111100 (RET)   PC <= pop
//   [18:16]=101 (Bcc)      cond=[15:14]: 00 Z, 01 ~Z, 10 C, 11 ~C
//     taken:     PC <= PC+1+sext(instruction[7:0])
//     not taken: PC <= PC+1
//   otherwise              PC <= PC+1
//  All PC arithmetic is ADDR_W bits, wrap-around; PC=4095 +1 -> 0.
//  Offset is two's complement -128..+127.
//  Stack: push writes stk[sp], sp++. Pop reads stk[sp-1], sp--. At most one push or pop per cycle.
//  Redirect latency: the target word is presented in the cycle after the control instruction.
//   No delay slot; the fetcher issues no flush.
//  start is ignored outside IDLE. FAULT is left only by reset.
// CONFIGURATION
//  FETCH_STACK_GUARD_EN defined:
//   JSB with sp==STACK_DEPTH, or RET with sp==0 -> PC and sp unchanged.
//   state=FAULT and fault=1 at the next edge; instr_valid=0 while in FAULT.
//  FETCH_STACK_GUARD_EN not defined:
//   no FAULT state; fault tied 0.
//   sp wraps modulo STACK_DEPTH; overflow overwrites the oldest entry.
//   Underflow pops the wrapped slot; no error is reported.
// TESTING
//  1 Reset: rst=0 mid-RUN with PC=0x123 -> address=0, state=IDLE, sp=0, instr_valid=0 immediately.
//  2 Sequential: start, NOP words -> address 0,1,2,3 on successive cycles, instr_valid=1.
//    Preload PC=4095 -> next address=0.
//  3 Call/return: JSB 0x014 at PC 14 -> address 20, sp=1.
//    RET at 20 -> address 15, sp=0.
//  4 Branch: {101,11,...,off=5} at PC 19 with flag_c=0 -> address 25.
//    Same word with flag_c=1 -> address 20. off=0xFE at PC 10 -> address 9.
//  5 Stall: stall=1 for 3 cycles on a JMP 0x034 -> address held, instr_valid=0.
//    stall released -> address 0x034 one cycle later.
//  6 Guard: 9 nested JSB with STACK_DEPTH=8.
//    With FETCH_STACK_GUARD_EN: the 9th JSB -> FAULT, fault=1, PC unchanged.
//    Without: sp wraps to 1, no fault, and the 9th RET returns the 9th pushed address.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for a 4096x19 instruction store: JMP/JSB/RET/Bcc decode with a return stack.
// Optional build macro FETCH_STACK_GUARD_EN turns stack over/underflow into a sticky FAULT state.
module fetch_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 19,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          flag_z,
    input  logic                          flag_c,
    input  logic [INSTR_W-1:0]            instruction,
    output logic [ADDR_W-1:0]             address,
    output logic [INSTR_W-1:0]            instr_out,
    output logic                          instr_valid,
    output logic [1:0]                    state,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic                          fault
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_next, w_pc_inc, w_br_target;
    logic [SP_W-1:0]     r_sp, w_sp_next, w_sp_inc, w_sp_dec;
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];
    logic [IDX_W-1:0]    w_push_idx, w_pop_idx;
    logic                w_exec, w_is_jmp, w_is_jsb, w_is_ret, w_is_bcc, w_taken;
    logic                w_push, w_trip, w_ovf, w_unf;
    logic                w_unused_bits;

    function automatic logic branch_cond(input logic [1:0] cc, input logic z, input logic c);
        logic res;
        case (cc)
            2'b00:   res = z;
            2'b01:   res = ~z;
            2'b10:   res = c;
            default: res = ~c;
        endcase
        return res;
    endfunction

    assign w_exec      = (r_state == ST_RUN) & ~stall;
    assign w_is_jmp    = (instruction[18:14] == 5'b11100);
    assign w_is_jsb    = (instruction[18:14] == 5'b11101);
    assign w_is_ret    = (instruction[18:13] == 6'b111100);
    assign w_is_bcc    = (instruction[18:16] == 3'b101);
    assign w_taken     = branch_cond(instruction[15:14], flag_z, flag_c);
    assign w_pc_inc    = r_pc + ADDR_W'(1'b1);
    assign w_br_target = w_pc_inc + {{(ADDR_W-8){instruction[7]}}, instruction[7:0]};
    assign w_push_idx  = r_sp[IDX_W-1:0];
    assign w_pop_idx   = w_push_idx - IDX_W'(1'b1);
    assign w_unused_bits = instruction[12];

`ifdef FETCH_STACK_GUARD_EN
    assign w_sp_inc = r_sp + SP_W'(1'b1);
    assign w_sp_dec = r_sp - SP_W'(1'b1);
    assign w_ovf    = (r_sp == SP_FULL);
    assign w_unf    = (r_sp == SP_W'(1'b0));
`else
    // Unguarded stack is a ring: occupancy stays modulo the depth, top bit always 0.
    assign w_sp_inc = {1'b0, w_push_idx + IDX_W'(1'b1)};
    assign w_sp_dec = {1'b0, w_pop_idx};
    assign w_ovf    = 1'b0;
    assign w_unf    = 1'b0;
`endif

    // Control-flow decode: next PC, stack pointer, push strobe and guard trip.
    always_comb begin
        w_pc_next = r_pc;
        w_sp_next = r_sp;
        w_push    = 1'b0;
        w_trip    = 1'b0;
        if (w_exec) begin
            if (w_is_jmp) begin
                w_pc_next = instruction[ADDR_W-1:0];
            end else if (w_is_jsb) begin
                if (w_ovf) begin
                    w_trip = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_sp_next = w_sp_inc;
                    w_pc_next = instruction[ADDR_W-1:0];
                end
            end else if (w_is_ret) begin
                if (w_unf) begin
                    w_trip = 1'b1;
                end else begin
                    w_sp_next = w_sp_dec;
                    w_pc_next = r_stack[w_pop_idx];
                end
            end else if (w_is_bcc) begin
                w_pc_next = w_taken ? w_br_target : w_pc_inc;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end else begin
            w_pc_next = r_pc;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;   else w_state_next = ST_IDLE;
            ST_RUN:   if (w_trip) w_state_next = ST_FAULT; else w_state_next = ST_RUN;
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        instr_valid = 1'b0;
        fault       = 1'b0;
        case (r_state)
            ST_RUN:   instr_valid = ~stall;
`ifdef FETCH_STACK_GUARD_EN
            ST_FAULT: fault = 1'b1;
`else
            ST_FAULT: fault = 1'b0;
`endif
            default:  instr_valid = 1'b0;
        endcase
    end

    // State, PC and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RST_PC;
            r_sp    <= SP_W'(1'b0);
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_sp    <= w_sp_next;
        end
    end

    // Return-address storage; contents are meaningless after reset so it carries none.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign address   = r_pc;
    assign instr_out = instruction;
    assign state     = r_state;
    assign sp        = r_sp;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random programs against a reference model.
module tb_fetch_sequencer;
    localparam int AW = 12, IW = 19, DEPTH = 8, MEMN = 4096;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0, flag_z = 1'b0, flag_c = 1'b0;
    logic [IW-1:0] instruction, instr_out;
    logic [AW-1:0] address;
    logic          instr_valid, fault;
    logic [1:0]    state;
    logic [3:0]    sp;
    logic [IW-1:0] imem [0:MEMN-1];

    assign instruction = imem[address];
    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .flag_z(flag_z), .flag_c(flag_c),
        .instruction(instruction), .address(address), .instr_out(instr_out),
        .instr_valid(instr_valid), .state(state), .sp(sp), .fault(fault));

    typedef struct { int addr; bit vld; int st; int sp; bit flt; logic [IW-1:0] word; } exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    // Reference model: integer PC, integer occupancy, array stack with per-slot "written" flags.
    int m_pc, m_sp, m_state;
    int m_stk[DEPTH];
    bit m_ok[DEPTH];
    bit m_lost;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] op_jmp(input logic [11:0] t); return {5'b11100, 2'b00, t}; endfunction
    function automatic logic [IW-1:0] op_jsb(input logic [11:0] t); return {5'b11101, 2'b00, t}; endfunction
    function automatic logic [IW-1:0] op_ret(); return {6'b111100, 13'd0}; endfunction
    function automatic logic [IW-1:0] op_bcc(input logic [1:0] cc, input logic [7:0] off);
        return {3'b101, cc, 6'd0, off};
    endfunction

    function automatic bit taken(input logic [1:0] cc);
        case (cc)
            2'd0:    return flag_z == 1'b1;
            2'd1:    return flag_z == 1'b0;
            2'd2:    return flag_c == 1'b1;
            default: return flag_c == 1'b0;
        endcase
    endfunction

    function automatic void m_reset();
        m_pc = 0; m_sp = 0; m_state = 0; m_lost = 1'b0;
        foreach (m_ok[i]) m_ok[i] = 1'b0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.addr = m_pc; e.vld = (m_state == 1) && !stall; e.st = m_state;
        e.sp = m_sp; e.flt = (m_state == 2); e.word = imem[m_pc];
        exp_q.push_back(e);
    endfunction

    function automatic void model_step();
        logic [IW-1:0] w;
        int nxt, off;
        if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (m_state == 1 && !stall) begin
            w = imem[m_pc];
            nxt = (m_pc + 1) % MEMN;
            if (w[18:14] == 5'b11100) begin
                m_pc = int'(w[11:0]);
            end else if (w[18:14] == 5'b11101) begin
`ifdef FETCH_STACK_GUARD_EN
                if (m_sp == DEPTH) m_state = 2;
                else begin m_stk[m_sp] = nxt; m_ok[m_sp] = 1'b1; m_sp++; m_pc = int'(w[11:0]); end
`else
                m_stk[m_sp] = nxt; m_ok[m_sp] = 1'b1; m_sp = (m_sp + 1) % DEPTH; m_pc = int'(w[11:0]);
`endif
            end else if (w[18:13] == 6'b111100) begin
`ifdef FETCH_STACK_GUARD_EN
                if (m_sp == 0) m_state = 2;
                else begin m_sp--; m_pc = m_stk[m_sp]; end
`else
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                if (m_ok[m_sp]) m_pc = m_stk[m_sp]; else m_lost = 1'b1;
`endif
            end else if (w[18:16] == 3'b101) begin
                off = int'($signed(w[7:0]));
                if (taken(w[15:14])) m_pc = (m_pc + 1 + off + MEMN) % MEMN;
                else m_pc = nxt;
            end else begin
                m_pc = nxt;
            end
        end
    endfunction

    // Called just after a rising edge: drive this cycle's inputs, log expectation, advance model.
    task automatic cycle(input bit st, input bit stl, input bit z, input bit c);
        start = st; stall = stl; flag_z = z; flag_c = c;
        push_exp();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        m_reset();
        #1;
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < n; i++) begin
            push_exp();
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMN; i++) imem[i] = '0;
    endtask

    function automatic logic [IW-1:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 12)      return op_jmp(12'($urandom));
        else if (r < 22) return op_jsb(12'($urandom));
        else if (r < 32) return op_ret();
        else if (r < 55) return op_bcc(2'($urandom), 8'($urandom));
        else             return 19'($urandom);
    endfunction

    // Monitor: every cycle the DUT presents a fetch; compare against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("address", 32'(address), e.addr);
            chk("instr_valid", 32'(instr_valid), 32'(e.vld));
            chk("state", 32'(state), e.st);
            chk("sp", 32'(sp), e.sp);
            chk("fault", 32'(fault), 32'(e.flt));
            chk("instr_out", 32'(instr_out), 32'(e.word));
        end
    end

    initial begin
        clear_mem();
        @(posedge clk); #1;
        do_reset(2);

        // Reset mid-RUN with PC=0x123 and one stacked return.
        imem[0] = op_jsb(12'h123);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_pc", 32'(address), 32'h123);
        chk("pre_reset_sp", 32'(sp), 32'd1);
        do_reset(2);

        // Sequential fetch and wrap from 4095.
        clear_mem();
        imem[3] = op_jmp(12'hFFF);
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq0", 32'(address), 32'd0);
        chk("seq0_valid", 32'(instr_valid), 32'd1);
        for (int a = 1; a <= 3; a++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            chk("seq", 32'(address), 32'(a));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_4095", 32'(address), 32'hFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap", 32'(address), 32'd0);

        // Call / return.
        clear_mem();
        imem[0] = op_jmp(12'd14); imem[14] = op_jsb(12'h014); imem[20] = op_ret();
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("jsb_addr", 32'(address), 32'd20);
        chk("jsb_sp", 32'(sp), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ret_addr", 32'(address), 32'd15);
        chk("ret_sp", 32'(sp), 32'd0);

        // Branches: ~C taken / not taken, negative offset on Z.
        clear_mem();
        imem[0] = op_jmp(12'd19); imem[19] = op_bcc(2'b11, 8'd5); imem[25] = op_jmp(12'd19);
        imem[20] = op_jmp(12'd10); imem[10] = op_bcc(2'b00, 8'hFE);
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bcc_taken", 32'(address), 32'd25);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bcc_not_taken", 32'(address), 32'd20);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bcc_negative", 32'(address), 32'd9);

        // Stall on a JMP.
        clear_mem();
        imem[0] = op_jmp(12'h034);
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; #1;
            chk("stall_valid", 32'(instr_valid), 32'd0);
            chk("stall_addr", 32'(address), 32'd0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("unstall_addr", 32'(address), 32'h034);
        chk("unstall_valid", 32'(instr_valid), 32'd1);

        // Nine nested calls against an eight-deep stack.
        clear_mem();
        for (int k = 0; k < 9; k++) begin
            imem[k*16]     = op_jsb(12'((k + 1) * 16));
            imem[k*16 + 1] = op_ret();
        end
        imem[144] = op_ret();
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_STACK_GUARD_EN
        chk("guard_state", 32'(state), 32'd2);
        chk("guard_fault", 32'(fault), 32'd1);
        chk("guard_pc", 32'(address), 32'd128);
        chk("guard_valid", 32'(instr_valid), 32'd0);
`else
        chk("wrap_sp", 32'(sp), 32'd1);
        chk("wrap_fault", 32'(fault), 32'd0);
        chk("wrap_pc", 32'(address), 32'd144);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ninth_ret", 32'(address), 32'd129);
`endif

        // Random programs with random stalls, flags, start and occasional resets.
        for (int i = 0; i < MEMN; i++) imem[i] = rand_word();
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            if (m_lost || $urandom_range(0, 299) == 0 || (m_state == 2 && $urandom_range(0, 19) == 0))
                do_reset(int'($urandom_range(1, 2)));
            else
                cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom));
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
